// File: rtl/plic_pkg.sv
// Shared definitions for the PLIC interrupt gateway: cell state encoding and ID decode helper.
package plic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLAIMED = 2'd2
  } cell_state_e;

  // One bit of the ID -> onehot decode; ID 0 and out-of-range IDs never match.
  function automatic logic id_is(input int unsigned id, input int unsigned src_id);
    return id == src_id;
  endfunction

endpackage

// File: rtl/plic_gateway_cell.sv
// One interrupt source: 2-flop synchroniser, rise detect, saturating edge counter and service FSM.
module plic_gateway_cell
  import plic_pkg::*;
#(
  parameter int EDGE_CNT_BITS = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic src_i,
  input  logic el_i,
  input  logic claim_hit_i,
  input  logic complete_hit_i,
  output logic ip_o,
  output logic claimed_o
);

  localparam logic [EDGE_CNT_BITS-1:0] CNT_MAX = '1;

  logic                     s1_q, s2_q, prev_q;
  logic [EDGE_CNT_BITS-1:0] cnt_q;
  cell_state_e              state_q;
  logic                     rise;

  assign rise      = s2_q & ~prev_q;
  assign ip_o      = (state_q == PENDING);
  assign claimed_o = (state_q == CLAIMED);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      s1_q   <= src_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;

      // Edges arriving while busy are banked for later re-pends; level mode keeps no bank.
      if (!el_i)
        cnt_q <= '0;
      else if (rise && state_q != IDLE && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (el_i) begin
            if (rise)
              state_q <= PENDING;
            else if (cnt_q != '0) begin
              state_q <= PENDING;
              cnt_q   <= cnt_q - 1'b1;
            end
          end else if (s2_q) begin
            state_q <= PENDING;
          end
        end
        PENDING: if (claim_hit_i)    state_q <= CLAIMED;
        CLAIMED: if (complete_hit_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/plic_gateway.sv
// PLIC gateway top: per-target in-service IDs, claim/complete arbitration and one cell per source.
module plic_gateway
  import plic_pkg::*;
#(
  parameter int SOURCES       = 8,
  parameter int SOURCES_BITS  = 4,
  parameter int TARGETS       = 1,
  parameter int EDGE_CNT_BITS = 3
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [SOURCES-1:0]                     src,
  input  logic [SOURCES:0]                       el,
  input  logic [TARGETS-1:0][SOURCES_BITS-1:0]   id,
  input  logic [TARGETS-1:0]                     claim,
  input  logic [TARGETS-1:0]                     complete,
  output logic [SOURCES-1:0]                     ip
);

  logic [TARGETS-1:0][SOURCES_BITS-1:0] svc_id_q, svc_id_d;
  logic [SOURCES-1:0] claim_hit, complete_hit, claimed;
  logic [SOURCES-1:0] claim_v, cmpl_v;
  logic               unused_el0;

  assign unused_el0 = el[0];

  // Targets are scanned in order and a source already taken this cycle is masked,
  // so the lowest-numbered target wins a contested claim.
  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    svc_id_d     = svc_id_q;
    claim_v      = '0;
    cmpl_v       = '0;
    for (int t = 0; t < TARGETS; t++) begin
      for (int i = 0; i < SOURCES; i++) begin
        claim_v[i] = id_is(32'(id[t]), unsigned'(i + 1)) & ip[i] & ~claim_hit[i];
        cmpl_v[i]  = id_is(32'(svc_id_q[t]), unsigned'(i + 1)) & claimed[i];
      end
      if (complete[t] && |cmpl_v) begin
        complete_hit = complete_hit | cmpl_v;
        svc_id_d[t]  = '0;
      end
      if (claim[t] && !complete[t] && |claim_v) begin
        claim_hit   = claim_hit | claim_v;
        svc_id_d[t] = id[t];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) svc_id_q <= '0;
    else       svc_id_q <= svc_id_d;
  end

  for (genvar g = 0; g < SOURCES; g++) begin : g_cell
    plic_gateway_cell #(
      .EDGE_CNT_BITS (EDGE_CNT_BITS)
    ) u_cell (
      .clk            (clk),
      .rstn           (rstn),
      .src_i          (src[g]),
      .el_i           (el[g+1]),
      .claim_hit_i    (claim_hit[g]),
      .complete_hit_i (complete_hit[g]),
      .ip_o           (ip[g]),
      .claimed_o      (claimed[g])
    );
  end

endmodule
